// File: rtl/crtc_pkg.sv
// Shared types and constants for the CRTC timing generator.
// Covers cursor mode encodings, vertical sequencing states and the sync-width-zero value.
package crtc_pkg;

    typedef enum logic [1:0] {
        CURSOR_STEADY  = 2'b00,
        CURSOR_OFF     = 2'b01,
        CURSOR_BLINK16 = 2'b10,
        CURSOR_BLINK32 = 2'b11
    } cursor_mode_t;

    typedef enum logic {
        ACTIVE_ROWS = 1'b0,
        ADJUST      = 1'b1
    } vstate_t;

    localparam int unsigned SYNC_WIDTH_ZERO = 16;

    // blink_bits[0] is frame_cnt[3], blink_bits[1] is frame_cnt[4]
    function automatic logic blink_phase(input logic [1:0] mode, input logic [1:0] blink_bits);
        case (cursor_mode_t'(mode))
            CURSOR_STEADY:  blink_phase = 1'b1;
            CURSOR_OFF:     blink_phase = 1'b0;
            CURSOR_BLINK16: blink_phase = blink_bits[0];
            CURSOR_BLINK32: blink_phase = blink_bits[1];
            default:        blink_phase = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/crtc_sync_pulse.sv
// Sync pulse stretcher: raises active on start and holds it for width advance strobes.
// A width of 0 stands for SYNC_WIDTH_ZERO strobes.
module crtc_sync_pulse
    import crtc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    input  logic       start,
    input  logic [3:0] width,
    output logic       active
);

    logic [3:0] remaining;
    logic [4:0] eff_width;

    always_comb begin
        eff_width = (width == '0) ? 5'(SYNC_WIDTH_ZERO) : {1'b0, width};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active    <= 1'b0;
            remaining <= '0;
        end else if (advance) begin
            if (start) begin
                active    <= 1'b1;
                remaining <= 4'(eff_width - 5'd1);
            end else if (active) begin
                if (remaining == '0)
                    active <= 1'b0;
                else
                    remaining <= remaining - 4'd1;
            end
        end
    end

endmodule

// File: rtl/crtc_timing_gen.sv
// 6845-style CRTC timing generator: character/row/scanline counters, video address,
// sync/active timing, frame counter and blinking hardware cursor.
module crtc_timing_gen
    import crtc_pkg::*;
#(
    parameter int unsigned CHAR_PIXELS = 8,
    parameter int unsigned H_WIDTH     = 8,
    parameter int unsigned V_WIDTH     = 7,
    parameter int unsigned RA_WIDTH    = 5,
    parameter int unsigned ADDR_WIDTH  = 12
) (
    input  logic                  pixel_clk,
    input  logic                  reset,
    input  logic [H_WIDTH-1:0]    h_char_total,
    input  logic [H_WIDTH-1:0]    h_char_displayed,
    input  logic [H_WIDTH-1:0]    h_sync_pos,
    input  logic [3:0]            h_sync_width,
    input  logic [RA_WIDTH-1:0]   v_char_height,
    input  logic [V_WIDTH-1:0]    v_char_total,
    input  logic [V_WIDTH-1:0]    v_char_displayed,
    input  logic [V_WIDTH-1:0]    v_sync_pos,
    input  logic [3:0]            v_sync_width,
    input  logic [RA_WIDTH-1:0]   v_adjust,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] cursor_addr,
    input  logic [RA_WIDTH-1:0]   cursor_start,
    input  logic [RA_WIDTH-1:0]   cursor_end,
    input  logic [1:0]            cursor_mode,
    output logic                  char_tick,
    output logic [ADDR_WIDTH-1:0] ma,
    output logic [RA_WIDTH-1:0]   ra,
    output logic                  h_sync,
    output logic                  v_sync,
    output logic                  h_active,
    output logic                  v_active,
    output logic                  display_en,
    output logic                  cursor,
    output logic                  frame_start
);

    localparam int unsigned PIX_W = $clog2(CHAR_PIXELS);

    logic [PIX_W-1:0]      pix_cnt;
    logic                  running;
    logic [H_WIDTH-1:0]    h_count, nh;
    logic [RA_WIDTH-1:0]   nra;
    logic [RA_WIDTH:0]     ra_plus1;
    logic [V_WIDTH-1:0]    v_count, nv;
    vstate_t               vstate, nstate;
    logic [ADDR_WIDTH-1:0] row_start, nrs, nma;
    logic [4:0]            frame_cnt, nfc;
    logic                  new_frame, line_end;
    logic                  n_hact, n_vact, n_cursor;
    logic                  h_sync_start, v_sync_start;

    always_comb begin
        char_tick = (pix_cnt == PIX_W'(CHAR_PIXELS - 1));
    end

    // The first char_tick after reset loads the top-left position instead of advancing,
    // so frame 0 shows character 0 at start_addr for a full character time.
    always_comb begin
        nh        = h_count;
        nra       = ra;
        nv        = v_count;
        nstate    = vstate;
        nrs       = row_start;
        nfc       = frame_cnt;
        new_frame = 1'b0;
        line_end  = 1'b0;
        ra_plus1  = {1'b0, ra} + 1'b1;
        if (!running) begin
            nh        = '0;
            nra       = '0;
            nv        = '0;
            nstate    = ACTIVE_ROWS;
            nrs       = start_addr;
            new_frame = 1'b1;
            line_end  = 1'b1;
        end else begin
            line_end = (h_count >= h_char_total);
            nh       = line_end ? '0 : h_count + 1'b1;
            if (vstate == ACTIVE_ROWS && ra == v_char_height && h_count == h_char_displayed)
                nrs = row_start + ADDR_WIDTH'(h_char_displayed);
            if (line_end) begin
                if (vstate == ACTIVE_ROWS) begin
                    if (ra >= v_char_height) begin
                        nra = '0;
                        if (v_count >= v_char_total) begin
                            if (v_adjust != '0)
                                nstate = ADJUST;
                            else
                                new_frame = 1'b1;
                        end else begin
                            nv = v_count + 1'b1;
                        end
                    end else begin
                        nra = ra + 1'b1;
                    end
                end else begin
                    if (ra_plus1 >= {1'b0, v_adjust})
                        new_frame = 1'b1;
                    else
                        nra = ra + 1'b1;
                end
                if (new_frame) begin
                    nv     = '0;
                    nra    = '0;
                    nstate = ACTIVE_ROWS;
                    nrs    = start_addr;
                    nfc    = frame_cnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        nma          = nrs + ADDR_WIDTH'(nh);
        n_hact       = (nh < h_char_displayed);
        n_vact       = (nstate == ACTIVE_ROWS) && (nv < v_char_displayed);
        n_cursor     = n_hact && n_vact && (nma == cursor_addr) &&
                       (cursor_start <= nra) && (nra <= cursor_end) &&
                       blink_phase(cursor_mode, nfc[4:3]);
        h_sync_start = (nh == h_sync_pos);
        v_sync_start = (nstate == ACTIVE_ROWS) && (nra == '0) && (nv == v_sync_pos);
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            pix_cnt     <= '0;
            running     <= 1'b0;
            h_count     <= '0;
            ra          <= '0;
            v_count     <= '0;
            vstate      <= ACTIVE_ROWS;
            row_start   <= '0;
            frame_cnt   <= '0;
            ma          <= '0;
            h_active    <= 1'b0;
            v_active    <= 1'b0;
            display_en  <= 1'b0;
            cursor      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_cnt     <= char_tick ? '0 : pix_cnt + 1'b1;
            frame_start <= 1'b0;
            if (char_tick) begin
                running     <= 1'b1;
                h_count     <= nh;
                ra          <= nra;
                v_count     <= nv;
                vstate      <= nstate;
                row_start   <= nrs;
                frame_cnt   <= nfc;
                ma          <= nma;
                h_active    <= n_hact;
                v_active    <= n_vact;
                display_en  <= n_hact && n_vact;
                cursor      <= n_cursor;
                frame_start <= new_frame;
            end
        end
    end

    crtc_sync_pulse u_h_sync (
        .clk     (pixel_clk),
        .rst     (reset),
        .advance (char_tick),
        .start   (h_sync_start),
        .width   (h_sync_width),
        .active  (h_sync)
    );

    crtc_sync_pulse u_v_sync (
        .clk     (pixel_clk),
        .rst     (reset),
        .advance (char_tick && line_end),
        .start   (v_sync_start),
        .width   (v_sync_width),
        .active  (v_sync)
    );

endmodule

// File: tb/tb_crtc_timing_gen.sv
// Directed bench for crtc_timing_gen: frame timing, address generation, wrap,
// sync widths, cursor blink modes and asynchronous reset.
module tb_crtc_timing_gen;

    logic        pixel_clk = 1'b0;
    logic        reset;
    logic [7:0]  h_char_total, h_char_displayed, h_sync_pos;
    logic [3:0]  h_sync_width, v_sync_width;
    logic [4:0]  v_char_height, v_adjust, cursor_start, cursor_end;
    logic [6:0]  v_char_total, v_char_displayed, v_sync_pos;
    logic [11:0] start_addr, cursor_addr;
    logic [1:0]  cursor_mode;
    logic        char_tick, h_sync, v_sync, h_active, v_active, display_en, cursor, frame_start;
    logic [11:0] ma;
    logic [4:0]  ra;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned cyc     = 0;
    int unsigned hs_rise = 0, hs_fall = 0, vs_rise = 0, vs_fall = 0;
    logic        hs_q = 1'b0, vs_q = 1'b0;
    int unsigned t1, t2, zeros;

    crtc_timing_gen #(
        .CHAR_PIXELS (8),
        .H_WIDTH     (8),
        .V_WIDTH     (7),
        .RA_WIDTH    (5),
        .ADDR_WIDTH  (12)
    ) dut (
        .pixel_clk        (pixel_clk),
        .reset            (reset),
        .h_char_total     (h_char_total),
        .h_char_displayed (h_char_displayed),
        .h_sync_pos       (h_sync_pos),
        .h_sync_width     (h_sync_width),
        .v_char_height    (v_char_height),
        .v_char_total     (v_char_total),
        .v_char_displayed (v_char_displayed),
        .v_sync_pos       (v_sync_pos),
        .v_sync_width     (v_sync_width),
        .v_adjust         (v_adjust),
        .start_addr       (start_addr),
        .cursor_addr      (cursor_addr),
        .cursor_start     (cursor_start),
        .cursor_end       (cursor_end),
        .cursor_mode      (cursor_mode),
        .char_tick        (char_tick),
        .ma               (ma),
        .ra               (ra),
        .h_sync           (h_sync),
        .v_sync           (v_sync),
        .h_active         (h_active),
        .v_active         (v_active),
        .display_en       (display_en),
        .cursor           (cursor),
        .frame_start      (frame_start)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    always @(negedge pixel_clk) begin
        if (h_sync && !hs_q) hs_rise <= cyc;
        if (!h_sync && hs_q) hs_fall <= cyc;
        if (v_sync && !vs_q) vs_rise <= cyc;
        if (!v_sync && vs_q) vs_fall <= cyc;
        hs_q <= h_sync;
        vs_q <= v_sync;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_defaults();
        h_char_total     = 8'd63;
        h_char_displayed = 8'd40;
        h_sync_pos       = 8'd44;
        h_sync_width     = 4'd4;
        v_char_height    = 5'd7;
        v_char_total     = 7'd31;
        v_char_displayed = 7'd25;
        v_sync_pos       = 7'd28;
        v_sync_width     = 4'd2;
        v_adjust         = 5'd0;
        start_addr       = 12'h000;
        cursor_addr      = 12'hFFF;
        cursor_start     = 5'd0;
        cursor_end       = 5'd0;
        cursor_mode      = 2'b01;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_flags"}, 32'({char_tick, h_sync, v_sync, h_active, v_active,
                                    display_en, cursor, frame_start}), 32'd0);
        check({tag, "_ma"}, 32'(ma), 32'd0);
        check({tag, "_ra"}, 32'(ra), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        repeat (2) @(posedge pixel_clk);
        #1;
        check_outputs_zero(tag);
        @(negedge pixel_clk);
        reset = 1'b0;
    endtask

    // Advance to the next character; returns 1 time unit after the updating edge.
    task automatic step_char();
        bit seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge pixel_clk);
            if (char_tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("char_tick_timeout", 32'(seen), 32'd1);
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic step_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step_char();
    endtask

    task automatic wait_fs(output int unsigned t);
        bit seen = 1'b0;
        t = 0;
        @(posedge pixel_clk);
        for (int i = 0; i < 4000; i++) begin
            @(negedge pixel_clk);
            if (frame_start) begin
                seen = 1'b1;
                t    = cyc;
                break;
            end
        end
        check("frame_start_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        // Minimal frame: 1 char x (8 rows + 4 adjust) scanlines
        set_defaults();
        h_char_total = 8'd0;  h_char_displayed = 8'd1; h_sync_pos = 8'd1; h_sync_width = 4'd1;
        v_char_height = 5'd7; v_char_total = 7'd0; v_char_displayed = 7'd1; v_adjust = 5'd4;
        v_sync_pos = 7'd100;  start_addr = 12'h123;
        do_reset("reset_t1");
        step_char();
        check("t1_load_frame_start", 32'(frame_start), 32'd1);
        check("t1_load_ma", 32'(ma), 32'h123);
        check("t1_load_display_en", 32'(display_en), 32'd1);
        zeros = 0;
        for (int i = 1; i <= 11; i++) begin
            step_char();
            if (!v_active) zeros++;
        end
        check("t1_vinactive_lines", zeros, 32'd4);
        check("t1_last_adjust_ra", 32'(ra), 32'd3);
        step_char();
        check("t1_frame_start_again", 32'(frame_start), 32'd1);
        wait_fs(t1);
        wait_fs(t2);
        check("t1_period", t2 - t1, 32'd96);

        // 40x25 layout with one scanline per row
        set_defaults();
        v_char_height = 5'd0; v_sync_pos = 7'd100;
        do_reset("reset_t2");
        step_char();
        check("t2_row0_first_ma", 32'(ma), 32'h000);
        step_n(39);
        check("t2_row0_last_ma", 32'(ma), 32'h027);
        check("t2_row0_last_hact", 32'(h_active), 32'd1);
        step_char();
        check("t2_row0_border_hact", 32'(h_active), 32'd0);
        step_n(24);
        check("t2_row1_first_ma", 32'(ma), 32'h028);
        step_n(39);
        check("t2_row1_last_ma", 32'(ma), 32'h04F);
        step_n(1472);
        check("t2_last_disp_ma", 32'(ma), 32'h3E7);
        check("t2_last_disp_en", 32'(display_en), 32'd1);
        step_char();
        check("t2_after_last_en", 32'(display_en), 32'd0);
        step_n(24);
        check("t2_row25_vact", 32'(v_active), 32'd0);
        check("t2_row25_ma", 32'(ma), 32'h3E8);

        // Address wrap within the first row
        set_defaults();
        start_addr = 12'hFF0; v_sync_pos = 7'd100;
        do_reset("reset_t3");
        step_char();
        check("t3_first_ma", 32'(ma), 32'hFF0);
        step_n(15);
        check("t3_ma_fff", 32'(ma), 32'hFFF);
        check("t3_hact_fff", 32'(h_active), 32'd1);
        step_char();
        check("t3_ma_wrap", 32'(ma), 32'h000);
        check("t3_hact_wrap", 32'(h_active), 32'd1);

        // Sync width 0 => 16 chars / 16 scanlines, v_sync spanning adjust and frame wrap
        set_defaults();
        h_sync_width = 4'd0; v_sync_width = 4'd0; v_char_total = 7'd3; v_char_displayed = 7'd2;
        v_sync_pos = 7'd3; v_adjust = 5'd4;
        do_reset("reset_t4");
        step_char();
        step_n(44);
        check("t4_hsync_start", 32'(h_sync), 32'd1);
        step_n(15);
        check("t4_hsync_last", 32'(h_sync), 32'd1);
        step_char();
        check("t4_hsync_end", 32'(h_sync), 32'd0);
        @(negedge pixel_clk);
        #1;
        check("t4_hsync_cycles", hs_fall - hs_rise, 32'd128);
        step_n(1475);
        check("t4_vsync_before", 32'(v_sync), 32'd0);
        step_char();
        check("t4_vsync_start", 32'(v_sync), 32'd1);
        step_n(576);
        check("t4_vsync_in_adjust", 32'(v_sync), 32'd1);
        check("t4_vact_in_adjust", 32'(v_active), 32'd0);
        step_n(447);
        check("t4_vsync_after_wrap", 32'(v_sync), 32'd1);
        step_char();
        check("t4_vsync_end", 32'(v_sync), 32'd0);
        @(negedge pixel_clk);
        #1;
        check("t4_vsync_cycles", vs_fall - vs_rise, 32'd8192);

        // Cursor: 10 chars x 8 scanlines per frame, cursor at ma 5, rows 6..7
        set_defaults();
        h_char_total = 8'd9; h_char_displayed = 8'd8; v_char_total = 7'd0; v_char_displayed = 7'd1;
        v_sync_pos = 7'd100; cursor_addr = 12'h005; cursor_start = 5'd6; cursor_end = 5'd7;
        cursor_mode = 2'b10;
        do_reset("reset_t5");
        step_char();
        step_n(65);
        check("t5_f0_cursor", 32'(cursor), 32'd0);
        step_n(640);
        check("t5_f8_ra6_cursor", 32'(cursor), 32'd1);
        step_char();
        check("t5_f8_ma6_cursor", 32'(cursor), 32'd0);
        step_n(9);
        check("t5_f8_ra7_cursor", 32'(cursor), 32'd1);
        step_n(60);
        check("t5_f9_ra5_cursor", 32'(cursor), 32'd0);
        step_n(490);
        check("t5_f15_cursor", 32'(cursor), 32'd1);
        step_n(80);
        check("t5_f16_cursor", 32'(cursor), 32'd0);
        cursor_mode = 2'b11;
        step_n(10);
        check("t5_f16_blink32", 32'(cursor), 32'd1);
        cursor_mode = 2'b01;
        step_n(630);
        check("t5_f24_mode_off", 32'(cursor), 32'd0);
        cursor_mode = 2'b00; cursor_start = 5'd7; cursor_end = 5'd6;
        step_n(80);
        check("t5_f25_inverted_rows", 32'(cursor), 32'd0);
        cursor_start = 5'd6; cursor_end = 5'd7;
        step_n(80);
        check("t5_f26_steady", 32'(cursor), 32'd1);

        // Reset mid-line at h_count 20, then nominal frame period of 160 chars
        set_defaults();
        h_char_total = 8'd31; h_char_displayed = 8'd24; v_char_height = 5'd1; v_char_total = 7'd1;
        v_char_displayed = 7'd2; v_adjust = 5'd1; v_sync_pos = 7'd100;
        do_reset("reset_t6");
        step_char();
        step_n(20);
        check("t6_pre_reset_ma", 32'(ma), 32'd20);
        #2;
        reset = 1'b1;
        #1;
        check_outputs_zero("t6_async_reset");
        @(negedge pixel_clk);
        reset = 1'b0;
        wait_fs(t1);
        wait_fs(t2);
        check("t6_period", t2 - t1, 32'd1280);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crtc_timing_gen.md
Name: crtc_timing_gen

Overview:
- Parametrised, 6845-style CRTC timing generator; successor to the fixed-width video_gen.
- Runs on the pixel clock. Produces character/row/scanline counters, the video memory address (ma), the character-ROM row address (ra), sync/active/display-enable and a hardware cursor with blink.
- Adds configurable counter widths, start address, vertical adjust, cursor and a frame counter.
- Timing values come from CPU-writable CRTC registers held outside this block.

Parameters:
- CHAR_PIXELS, 8: pixel clocks per character cell (>=2).
- H_WIDTH, 8: width of horizontal character counter and horizontal registers.
- V_WIDTH, 7: width of vertical character-row counter and vertical registers.
- RA_WIDTH, 5: width of scanline-in-row counter, v_char_height, v_adjust and cursor rows.
- ADDR_WIDTH, 12: width of ma, start_addr and cursor_addr.

Ports:
- pixel_clk  in  1  pixel clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- h_char_total  in  H_WIDTH  last horizontal character index (total-1).
- h_char_displayed  in  H_WIDTH  displayed characters per row.
- h_sync_pos  in  H_WIDTH  character index where h_sync begins.
- h_sync_width  in  4  h_sync length in characters; 0 means 16.
- v_char_height  in  RA_WIDTH  last scanline index within a row (height-1).
- v_char_total  in  V_WIDTH  last character-row index (total-1).
- v_char_displayed  in  V_WIDTH  displayed character rows.
- v_sync_pos  in  V_WIDTH  character row where v_sync begins.
- v_sync_width  in  4  v_sync length in scanlines; 0 means 16.
- v_adjust  in  RA_WIDTH  extra scanlines after the last row; 0 means none.
- start_addr  in  ADDR_WIDTH  ma of the top-left character.
- cursor_addr  in  ADDR_WIDTH  ma at which the cursor is drawn.
- cursor_start  in  RA_WIDTH  first cursor scanline.
- cursor_end  in  RA_WIDTH  last cursor scanline.
- cursor_mode  in  2  00 steady, 01 off, 10 blink /16, 11 blink /32.
- char_tick  out  1  one-cycle pulse on the last pixel of each character.
- ma  out  ADDR_WIDTH  video RAM address for the current character.
- ra  out  RA_WIDTH  scanline within the character row.
- h_sync  out  1  horizontal sync, active-high.
- v_sync  out  1  vertical sync, active-high.
- h_active  out  1  horizontal display region.
- v_active  out  1  vertical display region.
- display_en  out  1  h_active & v_active.
- cursor  out  1  cursor pixel enable.
- frame_start  out  1  one-cycle pulse when a new frame begins.

Behaviour:
- Reset (async): all counters, outputs and the frame counter go to 0; row_start goes to 0.
- First frame after reset is frame 0. At the first char_tick, ma and row_start load start_addr.
- Pixel counter: 0..CHAR_PIXELS-1. char_tick is high when it equals CHAR_PIXELS-1.
- All counters below advance only on char_tick.
- Horizontal:
  - h_count wraps to 0 when h_count >= h_char_total (>= so a shrunk total mid-line still terminates).
  - h_active = h_count < h_char_displayed.
  - h_sync is set when h_count == h_sync_pos. It clears after h_sync_width characters, counted by its own 4-bit counter; width 0 gives 16.
- End of scanline (h wrap):
  - ra increments.
  - When ra >= v_char_height, ra wraps to 0 and v_count increments.
- Vertical states: ACTIVE_ROWS -> ADJUST -> ACTIVE_ROWS.
  - When ra and v_count are both at terminal (>=) values: enter ADJUST if v_adjust != 0, otherwise start a new frame.
  - ADJUST counts v_adjust scanlines using ra from 0, then starts a new frame.
  - New frame: v_count=0, ra=0, frame_start pulses, frame counter increments.
- v_active = v_count < v_char_displayed, and is 0 in ADJUST.
- v_sync:
  - Starts at the first scanline (ra=0) of row v_sync_pos.
  - Lasts v_sync_width scanlines (0 gives 16) and may extend into ADJUST or across a frame wrap.
  - Counted in scanlines, independent of ra.
- Address generation:
  - ma = row_start + h_count, modulo 2^ADDR_WIDTH.
  - On the scanline where ra == v_char_height, at h_count == h_char_displayed: row_start <= row_start + h_char_displayed.
  - At frame start: row_start <= start_addr.
- Cursor:
  - cursor = display_en & (ma == cursor_addr) & (cursor_start <= ra <= cursor_end) & blink_phase.
  - blink_phase: 1 for mode 00; 0 for mode 01; frame_cnt[3] for mode 10; frame_cnt[4] for mode 11.
  - frame_cnt is 5 bits and wraps.
  - If cursor_start > cursor_end, the cursor is never drawn.
- Output timing: ma, ra and all status outputs are registered and change in the cycle after char_tick. Exception: char_tick itself is combinational from the pixel counter.
- Register inputs are sampled on use; mid-frame changes take effect at the next comparison with no lock-up.

Decomposition:
- Shared package crtc_pkg holds: cursor_mode encodings, vertical state enum (ACTIVE_ROWS, ADJUST), and the SYNC_WIDTH_ZERO=16 constant.
- One sub-module, crtc_sync_pulse: a 4-bit width counter with start strobe, instantiated twice (h_sync on char_tick, v_sync on scanline end).

Test Plan:
- Minimal frame: CHAR_PIXELS=8, h_total=0, h_disp=1, sync_pos=1, h_sync_width=1, v_char_height=7, v_total=0, v_disp=1, v_adjust=4.
  - Required: frame period = 8 px × 1 char × (8+4) scanlines = 96 pixel_clk.
  - Required: frame_start every 96 cycles; v_active low for the last 4 scanlines.
- 40×25 layout: h_total=63, h_disp=40, v_total=31, v_disp=25, start_addr=0x000.
  - Required: ma runs 0x000..0x027 on row 0 and 0x028.. on row 1.
  - Required: the last displayed character has ma=0x3E7.
- Wrap: start_addr=0xFF0, h_disp=40.
  - Required: ma goes 0xFFF then 0x000 within the first row; no glitch on h_active.
- Sync width 0: h_sync_width=0, v_sync_width=0.
  - Required: h_sync high for exactly 16 chars (128 cycles); v_sync high for exactly 16 scanlines, across the ADJUST boundary.
- Cursor: cursor_addr=0x005, start=6, end=7, mode=10.
  - Required: cursor high only at ma=0x005, ra∈{6,7}, and only in frames 8–15 of each 16.
  - Required: mode 01 never asserts cursor.
- Reset mid-line: assert reset at h_count=20.
  - Required: all outputs 0 asynchronously.
  - Required: after release, the first frame_start-to-frame_start period equals the nominal period.
